// File: rtl/multiply_fix_pkg.sv
// Purpose: shared constants and result-fitting helpers for the fixed-point multiplier.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
// PROD_W is the working width for every shifted/rounded product. It is wide enough
// for a full 64-bit product shifted left by up to 63 bits, plus a sign bit.
package multiply_fix_pkg;

  localparam int PROD_W = 128;

  typedef struct packed {
    logic              ovf;
    logic [PROD_W-1:0] dat;
  } fit_t;

  // True when r fits in out_w bits: signed means every bit from out_w-1 up
  // matches the sign bit; unsigned means every bit from out_w up is zero.
  function automatic logic fits(input logic [PROD_W-1:0] r, input int out_w, input logic sgn);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PROD_W; i++) begin
      if (sgn) begin
        if (i >= out_w - 1 && r[i] != r[PROD_W-1]) ok = 1'b0;
      end else begin
        if (i >= out_w && r[i]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Largest out_w-bit value: 0x7F..F signed, 0xFF..F unsigned.
  function automatic logic [PROD_W-1:0] max_val(input int out_w, input logic sgn);
    logic [PROD_W-1:0] v;
    v = '0;
    for (int i = 0; i < PROD_W; i++) v[i] = (i < out_w - (sgn ? 1 : 0));
    return v;
  endfunction

  // Smallest out_w-bit value: 0x80..0 signed, 0 unsigned (upper bits left clear).
  function automatic logic [PROD_W-1:0] min_val(input int out_w, input logic sgn);
    logic [PROD_W-1:0] v;
    v = '0;
    if (sgn) v[out_w-1] = 1'b1;
    return v;
  endfunction

  function automatic fit_t fit_sat(input logic [PROD_W-1:0] r, input int out_w, input logic sgn);
    fit_t f;
    f.ovf = !fits(r, out_w, sgn);
    f.dat = r;
    if (f.ovf) f.dat = (sgn && r[PROD_W-1]) ? min_val(out_w, sgn) : max_val(out_w, sgn);
    return f;
  endfunction

  // Truncation keeps r as-is; the caller takes the low out_w bits.
  function automatic fit_t fit_trunc(input logic [PROD_W-1:0] r, input int out_w, input logic sgn);
    fit_t f;
    f.ovf = !fits(r, out_w, sgn);
    f.dat = r;
    return f;
  endfunction

endpackage

// File: rtl/multiply_fix_if.sv
// Purpose: AXI-stream bundle for operands A/B and the result of multiply_fix_pipe.
// Ports: slave = multiplier view (consumes A/B, produces result); master = source/sink view.
// Backpressure: standard tvalid/tready on all three streams.
interface multiply_fix_if #(
  parameter int DATAWIDTH_IN_A = 32,
  parameter int DATAWIDTH_IN_B = 32,
  parameter int DATAWIDTH_OUT  = 60,
  parameter int LANES          = 1
);
  logic                              s_axis_a_tvalid;
  logic                              s_axis_a_tready;
  logic [LANES*DATAWIDTH_IN_A-1:0]   s_axis_a_tdata;
  logic                              s_axis_b_tvalid;
  logic                              s_axis_b_tready;
  logic [LANES*DATAWIDTH_IN_B-1:0]   s_axis_b_tdata;
  logic                              m_axis_result_tvalid;
  logic                              m_axis_result_tready;
  logic [LANES*DATAWIDTH_OUT-1:0]    m_axis_result_tdata;
  logic [LANES-1:0]                  m_axis_result_tuser;

  modport slave (
    input  s_axis_a_tvalid, s_axis_a_tdata, s_axis_b_tvalid, s_axis_b_tdata, m_axis_result_tready,
    output s_axis_a_tready, s_axis_b_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser
  );

  modport master (
    output s_axis_a_tvalid, s_axis_a_tdata, s_axis_b_tvalid, s_axis_b_tdata, m_axis_result_tready,
    input  s_axis_a_tready, s_axis_b_tready, m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tuser
  );
endinterface

// File: rtl/multiply_fix_lane.sv
// Purpose: one multiplier lane, S2 full product and S3 shift/round/fit register.
// Latency: 2 cycles from operand register to result register while en=1.
// Backpressure: all state holds when en=0.
// Ports: clk, rst (sync, active high), en, a_dat/b_dat (S1 operands), res_dat/res_ovf (S3 result).
// Build option: MULT_NONZERO_EN forces an exact-zero result to 1 (overflow flag untouched).
module multiply_fix_lane
  import multiply_fix_pkg::*;
#(
  parameter int AW       = 32,
  parameter int BW       = 32,
  parameter int OW       = 60,
  parameter int SIGNED   = 0,
  parameter int INVERSE  = 0,
  parameter int OUTADDR  = 4,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] a_dat,
  input  logic [BW-1:0] b_dat,
  output logic [OW-1:0] res_dat,
  output logic          res_ovf
);
  localparam int PW = AW + BW;
  // Half-LSB of the shifted result; only meaningful for a right shift by >0.
  localparam logic [PROD_W-1:0] RND =
    (ROUND != 0 && INVERSE == 0 && OUTADDR > 0) ? (PROD_W'(1) << ((OUTADDR > 0) ? OUTADDR - 1 : 0)) : '0;

  logic [PW-1:0]     a_ext, b_ext, p_d, p_q;
  logic [PROD_W-1:0] pe, pr, r;
  fit_t              fit;
  logic [OW-1:0]     res_d, res_q;
  logic              ovf_d, ovf_q;

  always_comb begin
    // Extending both operands to PW bits makes a plain PW-bit multiply exact
    // for two's-complement as well as unsigned operands.
    if (SIGNED != 0) begin
      a_ext = PW'($signed(a_dat));
      b_ext = PW'($signed(b_dat));
      pe    = PROD_W'($signed(p_q));
    end else begin
      a_ext = PW'(a_dat);
      b_ext = PW'(b_dat);
      pe    = PROD_W'(p_q);
    end
    p_d = a_ext * b_ext;
    pr  = pe + RND;
    if (INVERSE != 0)     r = pr << OUTADDR;
    else if (SIGNED != 0) r = $unsigned($signed(pr) >>> OUTADDR);
    else                  r = pr >> OUTADDR;
    fit   = (SATURATE != 0) ? fit_sat(r, OW, SIGNED != 0) : fit_trunc(r, OW, SIGNED != 0);
    res_d = fit.dat[OW-1:0];
    ovf_d = fit.ovf;
`ifdef MULT_NONZERO_EN
    if (res_d == '0) res_d = OW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      p_q   <= p_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign res_dat = res_q;
  assign res_ovf = ovf_q;
endmodule

// File: rtl/multiply_fix_pipe.sv
// Purpose: multi-lane pipelined fixed-point multiplier with joined A/B AXI-stream inputs.
// Latency: 3 cycles accept -> tvalid, 1 beat/cycle; whole pipe stalls while result is held.
// Backpressure: en = !tvalid | tready gates every stage and both operand readys (no skid).
// Ports: aclk, areset (sync, active high), bus (multiply_fix_if.slave), ovf_clr, ovf_sticky.
// Build option: MULT_NONZERO_EN (see multiply_fix_lane) replaces zero lane results with 1.
module multiply_fix_pipe
  import multiply_fix_pkg::*;
#(
  parameter int DATAWIDTH_IN_A = 32,
  parameter int DATAWIDTH_IN_B = 32,
  parameter int DATAWIDTH_OUT  = 60,
  parameter int LANES          = 1,
  parameter int SIGNED         = 0,
  parameter int INVERSE        = 0,
  parameter int OUTADDR        = 4,
  parameter int ROUND          = 0,
  parameter int SATURATE       = 1
) (
  input  logic           aclk,
  input  logic           areset,
  multiply_fix_if.slave  bus,
  input  logic           ovf_clr,
  output logic           ovf_sticky
);
  localparam int AW = DATAWIDTH_IN_A;
  localparam int BW = DATAWIDTH_IN_B;
  localparam int OW = DATAWIDTH_OUT;

  logic                  en, acc, fire;
  logic                  s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q, s3_vld_d, s3_vld_q;
  logic [LANES*AW-1:0]   a_d, a_q;
  logic [LANES*BW-1:0]   b_d, b_q;
  logic                  ovf_sticky_d, ovf_sticky_q;
  logic [LANES*OW-1:0]   res_dat;
  logic [LANES-1:0]      res_ovf;

  always_comb begin
    en           = !s3_vld_q || bus.m_axis_result_tready;
    acc          = bus.s_axis_a_tvalid && bus.s_axis_b_tvalid && en;
    fire         = s3_vld_q && bus.m_axis_result_tready;
    s1_vld_d     = s1_vld_q;
    s2_vld_d     = s2_vld_q;
    s3_vld_d     = s3_vld_q;
    a_d          = a_q;
    b_d          = b_q;
    ovf_sticky_d = ovf_sticky_q;
    if (en) begin
      s1_vld_d = acc;
      s2_vld_d = s1_vld_q;
      s3_vld_d = s2_vld_q;
    end
    if (acc) begin
      a_d = bus.s_axis_a_tdata;
      b_d = bus.s_axis_b_tdata;
    end
    // Set wins over clear when both happen in one cycle.
    if (ovf_clr)              ovf_sticky_d = 1'b0;
    if (fire && (|res_ovf))   ovf_sticky_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      s3_vld_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s2_vld_q     <= s2_vld_d;
      s3_vld_q     <= s3_vld_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    multiply_fix_lane #(
      .AW(AW), .BW(BW), .OW(OW), .SIGNED(SIGNED), .INVERSE(INVERSE),
      .OUTADDR(OUTADDR), .ROUND(ROUND), .SATURATE(SATURATE)
    ) u_lane (
      .clk     (aclk),
      .rst     (areset),
      .en      (en),
      .a_dat   (a_q[i*AW +: AW]),
      .b_dat   (b_q[i*BW +: BW]),
      .res_dat (res_dat[i*OW +: OW]),
      .res_ovf (res_ovf[i])
    );
  end

  // Each operand's ready depends on the partner's valid so neither side is
  // consumed alone.
  assign bus.s_axis_a_tready      = en && bus.s_axis_b_tvalid;
  assign bus.s_axis_b_tready      = en && bus.s_axis_a_tvalid;
  assign bus.m_axis_result_tvalid = s3_vld_q;
  assign bus.m_axis_result_tdata  = res_dat;
  assign bus.m_axis_result_tuser  = res_ovf;
  assign ovf_sticky               = ovf_sticky_q;
endmodule

// File: tb/tb_multiply_fix_pipe.sv
// Purpose: directed self-checking bench for multiply_fix_pipe, four 8x8->12 configurations
// driven in lockstep: u0 unsigned >>4, u1 signed >>4, u2 signed >>4 rounded, u3 unsigned <<4.
// Handshake/latency behaviour is observed on u0; arithmetic is checked on the relevant instance.
module tb_multiply_fix_pipe;
  int n_run = 0;
  int n_fail = 0;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       a_vld = 1'b0, b_vld = 1'b0, m_rdy = 1'b1, ovf_clr = 1'b0;
  logic [7:0] a_dat = 8'h00, b_dat = 8'h00;
  logic [3:0] sticky;

`ifdef MULT_NONZERO_EN
  localparam logic [11:0] ZERO_OUT = 12'h001;
`else
  localparam logic [11:0] ZERO_OUT = 12'h000;
`endif

  always #5 aclk = ~aclk;

  multiply_fix_if #(.DATAWIDTH_IN_A(8), .DATAWIDTH_IN_B(8), .DATAWIDTH_OUT(12), .LANES(1)) if0 (), if1 (), if2 (), if3 ();

  assign if0.s_axis_a_tvalid = a_vld; assign if0.s_axis_b_tvalid = b_vld; assign if0.s_axis_a_tdata = a_dat;
  assign if0.s_axis_b_tdata = b_dat;  assign if0.m_axis_result_tready = m_rdy;
  assign if1.s_axis_a_tvalid = a_vld; assign if1.s_axis_b_tvalid = b_vld; assign if1.s_axis_a_tdata = a_dat;
  assign if1.s_axis_b_tdata = b_dat;  assign if1.m_axis_result_tready = m_rdy;
  assign if2.s_axis_a_tvalid = a_vld; assign if2.s_axis_b_tvalid = b_vld; assign if2.s_axis_a_tdata = a_dat;
  assign if2.s_axis_b_tdata = b_dat;  assign if2.m_axis_result_tready = m_rdy;
  assign if3.s_axis_a_tvalid = a_vld; assign if3.s_axis_b_tvalid = b_vld; assign if3.s_axis_a_tdata = a_dat;
  assign if3.s_axis_b_tdata = b_dat;  assign if3.m_axis_result_tready = m_rdy;

  multiply_fix_pipe #(.DATAWIDTH_IN_A(8), .DATAWIDTH_IN_B(8), .DATAWIDTH_OUT(12), .LANES(1), .SIGNED(0),
    .INVERSE(0), .OUTADDR(4), .ROUND(0), .SATURATE(1))
    u0 (.aclk(aclk), .areset(areset), .bus(if0), .ovf_clr(ovf_clr), .ovf_sticky(sticky[0]));
  multiply_fix_pipe #(.DATAWIDTH_IN_A(8), .DATAWIDTH_IN_B(8), .DATAWIDTH_OUT(12), .LANES(1), .SIGNED(1),
    .INVERSE(0), .OUTADDR(4), .ROUND(0), .SATURATE(1))
    u1 (.aclk(aclk), .areset(areset), .bus(if1), .ovf_clr(ovf_clr), .ovf_sticky(sticky[1]));
  multiply_fix_pipe #(.DATAWIDTH_IN_A(8), .DATAWIDTH_IN_B(8), .DATAWIDTH_OUT(12), .LANES(1), .SIGNED(1),
    .INVERSE(0), .OUTADDR(4), .ROUND(1), .SATURATE(1))
    u2 (.aclk(aclk), .areset(areset), .bus(if2), .ovf_clr(ovf_clr), .ovf_sticky(sticky[2]));
  multiply_fix_pipe #(.DATAWIDTH_IN_A(8), .DATAWIDTH_IN_B(8), .DATAWIDTH_OUT(12), .LANES(1), .SIGNED(0),
    .INVERSE(1), .OUTADDR(4), .ROUND(0), .SATURATE(1))
    u3 (.aclk(aclk), .areset(areset), .bus(if3), .ovf_clr(ovf_clr), .ovf_sticky(sticky[3]));

  // Present one beat and hold it until u0 accepts (bounded). Returns just after the accepting edge.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge aclk);
    a_dat = a; b_dat = b; a_vld = 1'b1; b_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (if0.s_axis_a_tready) ok = 1'b1;
      @(posedge aclk);
      if (ok) break;
    end
    #1;
    a_vld = 1'b0; b_vld = 1'b0;
  endtask

  // Count falling edges until u0 shows tvalid; -1 if it never does.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge aclk); #1;
      if (if0.m_axis_result_tvalid) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; m_rdy = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk); #1;
    n_run++; if (if0.m_axis_result_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", if0.m_axis_result_tvalid); end
    n_run++; if (if0.m_axis_result_tdata !== 12'h000) begin n_fail++; $display("FAIL reset_tdata: got %h want 000", if0.m_axis_result_tdata); end
    n_run++; if (if3.m_axis_result_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b want 0", if3.m_axis_result_tuser); end
    n_run++; if (sticky !== 4'b0000) begin n_fail++; $display("FAIL reset_sticky: got %b want 0000", sticky); end
    n_run++; if (if0.s_axis_a_tready !== 1'b0) begin n_fail++; $display("FAIL reset_a_tready: got %b want 0", if0.s_axis_a_tready); end
    areset = 1'b0;
  endtask

  task automatic test_unsigned();
    bit ok; int lat;
    send_one(8'hFF, 8'hFF, ok);
    n_run++; if (ok !== 1'b1) begin n_fail++; $display("FAIL unsigned_accept: got %b want 1", ok); end
    wait_valid(lat);
    n_run++; if (lat != 3) begin n_fail++; $display("FAIL unsigned_latency: got %0d want 3", lat); end
    n_run++; if (if0.m_axis_result_tdata !== 12'hFE0) begin n_fail++; $display("FAIL unsigned_tdata: got %h want fe0", if0.m_axis_result_tdata); end
    n_run++; if (if0.m_axis_result_tuser !== 1'b0) begin n_fail++; $display("FAIL unsigned_tuser: got %b want 0", if0.m_axis_result_tuser); end
  endtask

  task automatic test_signed();
    bit ok; int lat;
    send_one(8'hFF, 8'h04, ok);
    wait_valid(lat);
    n_run++; if (lat != 3) begin n_fail++; $display("FAIL signed_latency: got %0d want 3", lat); end
    n_run++; if (if1.m_axis_result_tdata !== 12'hFFF) begin n_fail++; $display("FAIL signed_trunc_tdata: got %h want fff", if1.m_axis_result_tdata); end
    n_run++; if (if1.m_axis_result_tuser !== 1'b0) begin n_fail++; $display("FAIL signed_tuser: got %b want 0", if1.m_axis_result_tuser); end
    n_run++; if (if2.m_axis_result_tdata !== ZERO_OUT) begin n_fail++; $display("FAIL signed_round_tdata: got %h want %h", if2.m_axis_result_tdata, ZERO_OUT); end
    n_run++; if (if0.m_axis_result_tdata !== 12'h03F) begin n_fail++; $display("FAIL signed_unsigned_view: got %h want 03f", if0.m_axis_result_tdata); end
  endtask

  task automatic test_inverse();
    bit ok; int lat;
    @(negedge aclk); ovf_clr = 1'b1;
    @(negedge aclk); ovf_clr = 1'b0; #1;
    n_run++; if (sticky[3] !== 1'b0) begin n_fail++; $display("FAIL inverse_sticky_cleared: got %b want 0", sticky[3]); end
    send_one(8'h20, 8'h10, ok);
    wait_valid(lat);
    n_run++; if (if3.m_axis_result_tdata !== 12'hFFF) begin n_fail++; $display("FAIL inverse_sat_tdata: got %h want fff", if3.m_axis_result_tdata); end
    n_run++; if (if3.m_axis_result_tuser !== 1'b1) begin n_fail++; $display("FAIL inverse_tuser: got %b want 1", if3.m_axis_result_tuser); end
    n_run++; if (sticky[3] !== 1'b0) begin n_fail++; $display("FAIL inverse_sticky_before_fire: got %b want 0", sticky[3]); end
    n_run++; if (if0.m_axis_result_tdata !== 12'h020) begin n_fail++; $display("FAIL inverse_u0_tdata: got %h want 020", if0.m_axis_result_tdata); end
    @(negedge aclk); #1;
    n_run++; if (sticky[3] !== 1'b1) begin n_fail++; $display("FAIL inverse_sticky_set: got %b want 1", sticky[3]); end
    repeat (3) @(negedge aclk); #1;
    n_run++; if (sticky[3] !== 1'b1) begin n_fail++; $display("FAIL inverse_sticky_hold: got %b want 1", sticky[3]); end
    n_run++; if (sticky[0] !== 1'b0) begin n_fail++; $display("FAIL inverse_u0_sticky: got %b want 0", sticky[0]); end
    ovf_clr = 1'b1;
    @(negedge aclk); ovf_clr = 1'b0; #1;
    n_run++; if (sticky[3] !== 1'b0) begin n_fail++; $display("FAIL inverse_sticky_clr: got %b want 0", sticky[3]); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_tbl [10] = '{12'd2, 12'd6, 12'd12, 12'd20, 12'd30, 12'd42, 12'd56, 12'd72, 12'd90, 12'd110};
    int sent = 0, got = 0, extra = 0;
    bit blocked = 1'b0, acc;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      @(negedge aclk);
      m_rdy = !(cyc >= 5 && cyc < 9);
      a_vld = (sent < 10); b_vld = (sent < 10);
      a_dat = 8'(16 * (sent + 1)); b_dat = 8'(sent + 2);
      #1;
      if (!m_rdy && a_vld && !if0.s_axis_a_tready) blocked = 1'b1;
      if (if0.m_axis_result_tvalid && m_rdy && got < 10) begin
        n_run++;
        if (if0.m_axis_result_tdata !== exp_tbl[got]) begin
          n_fail++; $display("FAIL stream_beat%0d: got %0d want %0d", got, if0.m_axis_result_tdata, exp_tbl[got]);
        end
        got++;
      end
      acc = a_vld && if0.s_axis_a_tready;
      @(posedge aclk);
      if (acc) sent++;
    end
    #1; a_vld = 1'b0; b_vld = 1'b0; m_rdy = 1'b1;
    n_run++; if (got != 10) begin n_fail++; $display("FAIL stream_count: got %0d want 10", got); end
    n_run++; if (blocked !== 1'b1) begin n_fail++; $display("FAIL stream_ready_drop: got %b want 1", blocked); end
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk); #1;
      if (if0.m_axis_result_tvalid) extra++;
    end
    n_run++; if (extra != 0) begin n_fail++; $display("FAIL stream_no_dup: got %0d extra beats want 0", extra); end
  endtask

  task automatic test_lone();
    bit lone_bad = 1'b0;
    int nv = 0;
    logic [11:0] seen = 12'h000;
    m_rdy = 1'b1;
    @(negedge aclk);
    a_dat = 8'h03; b_dat = 8'h20; a_vld = 1'b1; b_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (if0.s_axis_a_tready || if0.m_axis_result_tvalid) lone_bad = 1'b1;
      @(negedge aclk);
    end
    n_run++; if (lone_bad !== 1'b0) begin n_fail++; $display("FAIL lone_no_accept: got %b want 0", lone_bad); end
    b_vld = 1'b1; #1;
    n_run++; if (if0.s_axis_a_tready !== 1'b1) begin n_fail++; $display("FAIL lone_join_ready: got %b want 1", if0.s_axis_a_tready); end
    @(posedge aclk); #1;
    a_vld = 1'b0; b_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk); #1;
      if (if0.m_axis_result_tvalid) begin nv++; seen = if0.m_axis_result_tdata; end
    end
    n_run++; if (nv != 1) begin n_fail++; $display("FAIL lone_beat_count: got %0d want 1", nv); end
    n_run++; if (seen !== 12'h006) begin n_fail++; $display("FAIL lone_tdata: got %h want 006", seen); end
  endtask

  task automatic test_zero();
    bit ok; int lat;
    send_one(8'h00, 8'h05, ok);
    wait_valid(lat);
    n_run++; if (if0.m_axis_result_tdata !== ZERO_OUT) begin n_fail++; $display("FAIL zero_u0_tdata: got %h want %h", if0.m_axis_result_tdata, ZERO_OUT); end
    n_run++; if (if1.m_axis_result_tdata !== ZERO_OUT) begin n_fail++; $display("FAIL zero_u1_tdata: got %h want %h", if1.m_axis_result_tdata, ZERO_OUT); end
    n_run++; if (if0.m_axis_result_tuser !== 1'b0) begin n_fail++; $display("FAIL zero_tuser: got %b want 0", if0.m_axis_result_tuser); end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    m_rdy = 1'b1;
    @(negedge aclk);
    a_dat = 8'h40; b_dat = 8'h10; a_vld = 1'b1; b_vld = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    n_run++; if (if0.m_axis_result_tvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_inflight: got %b want 1", if0.m_axis_result_tvalid); end
    areset = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
    @(negedge aclk); #1;
    n_run++; if (if0.m_axis_result_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid: got %b want 0", if0.m_axis_result_tvalid); end
    n_run++; if (if0.m_axis_result_tdata !== 12'h000) begin n_fail++; $display("FAIL rstmid_tdata: got %h want 000", if0.m_axis_result_tdata); end
    areset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk); #1;
      if (if0.m_axis_result_tvalid) nv++;
    end
    n_run++; if (nv != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d beats want 0", nv); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_inverse();
    test_back_to_back();
    test_lone();
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
